// File: rtl/seq_mult_cla_pkg.sv
// Shared types and constants for the iterative CLA multiplier.
// Holds FSM encoding, default width, group size and counter sizing.
package seq_mult_cla_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int CLA_GRP   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_mult_cla_if.sv
// Start/busy/done handshake between execute stage and multiplier.
// master: start, mcand, mplier out; busy, done, product in.
interface seq_mult_cla_if
  import seq_mult_cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic               start;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, mcand, mplier,
    input  busy, done, product
  );

  modport slave (
    input  start, mcand, mplier,
    output busy, done, product
  );

endinterface

// File: rtl/seq_mult_cla_cla_nbit.sv
// Two-level carry-lookahead adder built from 4-bit groups.
// Ports: A, B, Cin in; sum, Cout out. Purely combinational.
module cla_nbit
  import seq_mult_cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] sum,
  output logic             Cout
);

  localparam int NG = WIDTH / CLA_GRP;

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_c;
  logic [NG-1:0]    w_gp;
  logic [NG-1:0]    w_gg;
  logic [NG:0]      w_gc;

  assign w_p = A ^ B;
  assign w_g = A & B;

  // Group propagate/generate, expanded sum-of-products form.
  always_comb begin
    logic acc;
    logic pr;
    acc  = 1'b0;
    pr   = 1'b0;
    w_gp = '0;
    w_gg = '0;
    for (int k = 0; k < NG; k++) begin
      w_gp[k] = &w_p[CLA_GRP*k +: CLA_GRP];
      acc = 1'b0;
      pr  = 1'b1;
      for (int j = CLA_GRP-1; j >= 0; j--) begin
        acc = acc | (pr & w_g[CLA_GRP*k+j]);
        pr  = pr & w_p[CLA_GRP*k+j];
      end
      w_gg[k] = acc;
    end
  end

  // Second level: each group carry-in straight from Cin and G/P.
  always_comb begin
    logic acc;
    logic pr;
    acc  = 1'b0;
    pr   = 1'b0;
    w_gc = '0;
    w_gc[0] = Cin;
    for (int k = 0; k < NG; k++) begin
      acc = 1'b0;
      pr  = 1'b1;
      for (int j = k; j >= 0; j--) begin
        acc = acc | (pr & w_gg[j]);
        pr  = pr & w_gp[j];
      end
      w_gc[k+1] = acc | (pr & Cin);
    end
  end

  // Bit carries inside each group from that group's carry-in.
  always_comb begin
    logic acc;
    logic pr;
    acc = 1'b0;
    pr  = 1'b0;
    w_c = '0;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < CLA_GRP; i++) begin
        acc = 1'b0;
        pr  = 1'b1;
        for (int j = i-1; j >= 0; j--) begin
          acc = acc | (pr & w_g[CLA_GRP*k+j]);
          pr  = pr & w_p[CLA_GRP*k+j];
        end
        w_c[CLA_GRP*k+i] = acc | (pr & w_gc[k]);
      end
    end
  end

  assign sum  = w_p ^ w_c;
  assign Cout = w_gc[NG];

endmodule

// File: rtl/seq_mult_cla.sv
// Iterative unsigned shift-add multiplier, one CLA add per cycle.
// Ports: clk, rst_n; bus (slave): start/mcand/mplier in, busy/done/product out.
module seq_mult_cla
  import seq_mult_cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_mult_cla_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t           r_state;
  state_t           w_nstate;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_last;
  logic             w_load;
  logic             w_step;

  assign w_last   = (r_cnt == CW'(WIDTH-1));
  assign w_load   = (r_state == ST_IDLE) && bus.start;
  assign w_step   = (r_state == ST_RUN);
  assign w_addend = r_mplier[0] ? r_mcand : '0;

  cla_nbit #(
    .WIDTH (WIDTH)
  ) u_cla (
    .A    (r_acc_hi),
    .B    (w_addend),
    .Cin  (1'b0),
    .sum  (w_sum),
    .Cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nstate;
  end

  // Encoding 2'b11 falls to default and recovers to IDLE.
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_nstate = ST_RUN;
      ST_RUN:  if (w_last)    w_nstate = ST_DONE;
      ST_DONE: w_nstate = ST_IDLE;
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_load) begin
      r_mcand  <= bus.mcand;
      r_acc_hi <= '0;
      r_mplier <= bus.mplier;
      r_cnt    <= '0;
    end else if (w_step) begin
      // Carry-out becomes the new MSB of the high half.
      {r_acc_hi, r_mplier} <= {w_cout, w_sum, r_mplier[WIDTH-1:1]};
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.product = {r_acc_hi, r_mplier};

endmodule

// File: tb/tb_seq_mult_cla.sv
// Bench for seq_mult_cla: abstract cycle model plus directed vectors.
module tb_seq_mult_cla;

  localparam int W = 16;

  logic clk;
  logic rst_n;

  seq_mult_cla_if #(.WIDTH(W)) bus ();

  seq_mult_cla #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted start makes the unit busy for W+1 cycles,
  // the last of which carries done and the full product.
  bit          m_act  = 1'b0;
  int          m_k    = 0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_last = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act  = 1'b0;
      m_k    = 0;
      m_last = '0;
    end else if (!m_act) begin
      if (bus.start) begin
        m_act = 1'b1;
        m_k   = 0;
        m_res = 32'(bus.mcand) * 32'(bus.mplier);
      end
    end else begin
      m_k++;
      if (m_k == W + 1) begin
        m_act  = 1'b0;
        m_last = m_res;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("busy", 64'(bus.busy), 64'(m_act));
    check("done", 64'(bus.done), 64'(m_act && m_k == W));
    if (!m_act)
      check("hold", 64'(bus.product), 64'(m_last));
    else if (m_k == W)
      check("prod", 64'(bus.product), 64'(m_res));
  end

  task automatic run_op(input  logic [15:0] a,
                        input  logic [15:0] b,
                        output logic [31:0] p,
                        output int          lat,
                        output logic        b1);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = a;
    bus.mplier = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mcand  = 16'($urandom);
    bus.mplier = 16'($urandom);
    b1  = bus.busy;
    lat = 0;
    p   = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.done) begin
        lat = c;
        p   = bus.product;
        break;
      end
    end
    if (lat == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: no done within 40 cycles for %0h*%0h", a, b);
    end
  endtask

  logic [31:0] p;
  int          lat;
  logic        b1;
  int          ndone;
  logic [15:0] ra;
  logic [15:0] rb;

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.mcand  = '0;
    bus.mplier = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_prod", 64'(bus.product), 64'd0);
    rst_n = 1'b1;

    run_op(16'd3, 16'd5, p, lat, b1);
    check("3x5_lat", 64'(lat), 64'd17);
    check("3x5_busy1", 64'(b1), 64'd1);
    check("3x5_prod", 64'(p), 64'h0000_000F);
    @(negedge clk);
    check("3x5_idle", 64'(bus.busy), 64'd0);
    check("3x5_nodone", 64'(bus.done), 64'd0);

    run_op(16'hFFFF, 16'hFFFF, p, lat, b1);
    check("ffxff_prod", 64'(p), 64'hFFFE_0001);

    run_op(16'h1234, 16'h0000, p, lat, b1);
    check("x0_lat", 64'(lat), 64'd17);
    check("x0_prod", 64'(p), 64'd0);
    run_op(16'h0000, 16'hABCD, p, lat, b1);
    check("0x_lat", 64'(lat), 64'd17);
    check("0x_prod", 64'(p), 64'd0);

    // start held high, operands changing every cycle
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = 16'd7;
    bus.mplier = 16'd9;
    ndone = 0;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (i == 17) check("held_p1", 64'(bus.product), 64'd63);
      if (i == 35) check("held_p2", 64'(bus.product), 64'd399);
      bus.mcand  = 16'(i + 1);
      bus.mplier = 16'(i + 3);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("held_ndone", 64'(ndone), 64'd2);
    repeat (3) @(negedge clk);

    // reset in the middle of an operation
    bus.start  = 1'b1;
    bus.mcand  = 16'h8000;
    bus.mplier = 16'h0002;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_prod", 64'(bus.product), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd100, 16'd200, p, lat, b1);
    check("after_rst_prod", 64'(p), 64'd20000);

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, p, lat, b1);
      check("rnd_prod", 64'(p), 64'(32'(ra) * 32'(rb)));
      check("rnd_lat", 64'(lat), 64'd17);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
